// File: rtl/bp_next_pc_pkg.sv
// Shared definitions for the fetch-stage next-PC predictor: default widths,
// 2-bit counter encodings and the saturating counter update rule.
package bp_next_pc_pkg;

   localparam int BP_XLEN       = 32;
   localparam int BP_INDEX_BITS = 4;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   // Move one step toward the observed outcome, clamping at SNT/ST.
   function automatic logic [1:0] ctr_sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != ST) res = ctr + 2'd1;
      end else begin
         if (ctr != SNT) res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/bp_btb_table.sv
// Direct-mapped BTB/BHT storage: per-entry valid, tag, target and 2-bit counter,
// cleared by synchronous reset, one write port and two asynchronous read ports.
module bp_btb_table
   import bp_next_pc_pkg::*;
#(
   parameter int XLEN       = BP_XLEN,
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int TAG_BITS   = XLEN - INDEX_BITS - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] ra_idx,
   output logic                  ra_valid,
   output logic [TAG_BITS-1:0]   ra_tag,
   output logic [XLEN-1:0]       ra_target,
   output logic [1:0]            ra_ctr,
   input  logic [INDEX_BITS-1:0] rb_idx,
   output logic                  rb_valid,
   output logic [TAG_BITS-1:0]   rb_tag,
   output logic [XLEN-1:0]       rb_target,
   output logic [1:0]            rb_ctr,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_idx,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [XLEN-1:0]       wr_target,
   input  logic [1:0]            wr_ctr
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic                valid_reg  [ENTRIES];
   logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
   logic [XLEN-1:0]     target_reg [ENTRIES];
   logic [1:0]          ctr_reg    [ENTRIES];

   // Whole-table clear on reset rules out block RAM, so each entry is its own register.
   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_reg[gi]  <= 1'b0;
            tag_reg[gi]    <= '0;
            target_reg[gi] <= '0;
            ctr_reg[gi]    <= WNT;
         end else if (wr_en && wr_idx == INDEX_BITS'(gi)) begin
            valid_reg[gi]  <= 1'b1;
            tag_reg[gi]    <= wr_tag;
            target_reg[gi] <= wr_target;
            ctr_reg[gi]    <= wr_ctr;
         end
      end
   end

   assign ra_valid  = valid_reg[ra_idx];
   assign ra_tag    = tag_reg[ra_idx];
   assign ra_target = target_reg[ra_idx];
   assign ra_ctr    = ctr_reg[ra_idx];

   assign rb_valid  = valid_reg[rb_idx];
   assign rb_tag    = tag_reg[rb_idx];
   assign rb_target = target_reg[rb_idx];
   assign rb_ctr    = ctr_reg[rb_idx];

endmodule

// File: rtl/bp_next_pc.sv
// Next-PC generator: BTB lookup on pc_if, EX redirect priority, PC clock enable,
// table training from EX and the prediction metadata register for ID.
module bp_next_pc
   import bp_next_pc_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int XLEN       = BP_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_if,
   input  logic            stall_if,
   output logic [XLEN-1:0] npc,
   output logic            pc_ce,
   output logic            pred_taken_if,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_mispredict,
   input  logic [XLEN-1:0] ex_correct_pc,
   output logic            pred_taken_id,
   output logic [XLEN-1:0] pred_target_id
);

   localparam int TAG_BITS = XLEN - INDEX_BITS - 2;

   logic [INDEX_BITS-1:0] if_idx, ex_idx;
   logic [TAG_BITS-1:0]   if_tag, ex_tag;

   logic                  if_valid, ex_valid_entry;
   logic [TAG_BITS-1:0]   if_tag_q, ex_tag_q;
   logic [XLEN-1:0]       pred_target, ex_target_q;
   logic [1:0]            if_ctr, ex_ctr;

   logic                  wr_en;
   logic [XLEN-1:0]       wr_target;
   logic [1:0]            wr_ctr;
   logic                  ex_hit;

   logic                  pred_taken_id_reg, pred_taken_id_next;
   logic [XLEN-1:0]       pred_target_id_reg, pred_target_id_next;

   // Instructions are word aligned, so the low two PC bits carry no information.
   logic                  unused_low_bits;
   assign unused_low_bits = &{1'b0, pc_if[1:0], ex_pc[1:0]};

   assign if_idx = pc_if[INDEX_BITS+1:2];
   assign if_tag = pc_if[XLEN-1:INDEX_BITS+2];
   assign ex_idx = ex_pc[INDEX_BITS+1:2];
   assign ex_tag = ex_pc[XLEN-1:INDEX_BITS+2];

   bp_btb_table #(
      .XLEN       (XLEN),
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_table (
      .clk       (clk),
      .rst       (rst),
      .ra_idx    (if_idx),
      .ra_valid  (if_valid),
      .ra_tag    (if_tag_q),
      .ra_target (pred_target),
      .ra_ctr    (if_ctr),
      .rb_idx    (ex_idx),
      .rb_valid  (ex_valid_entry),
      .rb_tag    (ex_tag_q),
      .rb_target (ex_target_q),
      .rb_ctr    (ex_ctr),
      .wr_en     (wr_en),
      .wr_idx    (ex_idx),
      .wr_tag    (ex_tag),
      .wr_target (wr_target),
      .wr_ctr    (wr_ctr)
   );

   assign pred_taken_if = if_valid && (if_tag_q == if_tag) && if_ctr[1];
   assign ex_hit        = ex_valid_entry && (ex_tag_q == ex_tag);

   always_comb begin
      wr_en     = 1'b0;
      wr_target = ex_target_q;
      wr_ctr    = ex_ctr;
      if (ex_valid && ex_is_branch) begin
         if (ex_hit) begin
            wr_en  = 1'b1;
            wr_ctr = ctr_sat_update(ex_ctr, ex_taken);
            if (ex_taken) wr_target = ex_target;
         end else if (ex_taken) begin
            // A taken miss evicts whatever aliases this index.
            wr_en     = 1'b1;
            wr_target = ex_target;
            wr_ctr    = WT;
         end
      end
   end

   always_comb begin
      npc = pc_if + XLEN'(4);
      if (ex_mispredict)      npc = ex_correct_pc;
      else if (pred_taken_if) npc = pred_target;
   end

   assign pc_ce = ~stall_if | ex_mispredict;

   always_comb begin
      pred_taken_id_next  = pred_taken_id_reg;
      pred_target_id_next = pred_target_id_reg;
      if (ex_mispredict) begin
         pred_taken_id_next  = 1'b0;
         pred_target_id_next = '0;
      end else if (!stall_if) begin
         pred_taken_id_next  = pred_taken_if;
         pred_target_id_next = pred_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pred_taken_id_reg  <= 1'b0;
         pred_target_id_reg <= '0;
      end else begin
         pred_taken_id_reg  <= pred_taken_id_next;
         pred_target_id_reg <= pred_target_id_next;
      end
   end

   assign pred_taken_id  = pred_taken_id_reg;
   assign pred_target_id = pred_target_id_reg;

endmodule

// File: tb/tb_bp_next_pc.sv
// Directed scenarios followed by random traffic, checked against a table-level
// behavioural model of the predictor.
module tb_bp_next_pc;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_if;
   logic        stall_if;
   logic [31:0] npc;
   logic        pc_ce;
   logic        pred_taken_if;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_mispredict;
   logic [31:0] ex_correct_pc;
   logic        pred_taken_id;
   logic [31:0] pred_target_id;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit          m_valid  [16];
   int unsigned m_tag    [16];
   logic [31:0] m_target [16];
   int          m_ctr    [16];
   bit          m_id_taken;
   logic [31:0] m_id_target;

   always #5 clk = ~clk;

   bp_next_pc dut (
      .clk            (clk),
      .rst            (rst),
      .pc_if          (pc_if),
      .stall_if       (stall_if),
      .npc            (npc),
      .pc_ce          (pc_ce),
      .pred_taken_if  (pred_taken_if),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_mispredict  (ex_mispredict),
      .ex_correct_pc  (ex_correct_pc),
      .pred_taken_id  (pred_taken_id),
      .pred_target_id (pred_target_id)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      int i;
      i = m_idx(pc);
      return m_valid[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2;
   endfunction

   function automatic logic [31:0] m_npc();
      if (ex_mispredict)  return ex_correct_pc;
      if (m_pred(pc_if))  return m_target[m_idx(pc_if)];
      return pc_if + 32'd4;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = 0;
         m_target[i] = '0;
         m_ctr[i]    = 1;
      end
      m_id_taken  = 1'b0;
      m_id_target = '0;
   endtask

   task automatic m_clock();
      bit          p;
      logic [31:0] pt;
      int          i;
      bit          hit;
      p  = m_pred(pc_if);
      pt = m_target[m_idx(pc_if)];
      if (rst) begin
         m_reset();
         return;
      end
      if (ex_mispredict) begin
         m_id_taken  = 1'b0;
         m_id_target = '0;
      end else if (!stall_if) begin
         m_id_taken  = p;
         m_id_target = pt;
      end
      if (ex_valid && ex_is_branch) begin
         i   = m_idx(ex_pc);
         hit = m_valid[i] && m_tag[i] == (ex_pc >> 6);
         if (hit && ex_taken) begin
            m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_target[i] = ex_target;
         end else if (hit) begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
         end else if (ex_taken) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = ex_pc >> 6;
            m_target[i] = ex_target;
            m_ctr[i]    = 2;
         end
      end
   endtask

   // One clock: compare combinational outputs mid-cycle, then registered ones after the edge.
   task automatic cycle();
      @(negedge clk);
      check("npc", npc, m_npc());
      check("pc_ce", 32'(pc_ce), 32'(!stall_if || ex_mispredict));
      check("pred_taken_if", 32'(pred_taken_if), 32'(m_pred(pc_if)));
      @(posedge clk);
      m_clock();
      #1;
      check("pred_taken_id", 32'(pred_taken_id), 32'(m_id_taken));
      check("pred_target_id", pred_target_id, m_id_target);
   endtask

   task automatic ex_idle();
      ex_valid = 0; ex_is_branch = 0; ex_pc = '0; ex_taken = 0;
      ex_target = '0; ex_mispredict = 0; ex_correct_pc = '0;
   endtask

   task automatic ex_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
      ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_taken = taken; ex_target = tgt;
   endtask

   initial begin
      rst = 1; stall_if = 0; pc_if = 32'h100;
      ex_idle();
      @(posedge clk);
      m_reset();
      #1;
      rst = 0;

      // 1: reset state
      #1;
      check("t1_npc", npc, 32'h104);
      check("t1_pred", 32'(pred_taken_if), 32'd0);
      check("t1_ce", 32'(pc_ce), 32'd1);
      cycle();
      check("t1_id", 32'(pred_taken_id), 32'd0);

      // 2: allocate, strengthen, weaken
      ex_update(32'h100, 1, 32'h200);
      cycle();
      ex_idle(); #1;
      check("t2_pred", 32'(pred_taken_if), 32'd1);
      check("t2_npc", npc, 32'h200);
      ex_update(32'h100, 1, 32'h200); cycle();
      ex_update(32'h100, 0, 32'h0);   cycle();
      ex_update(32'h100, 0, 32'h0);   cycle();
      ex_idle(); #1;
      check("t2_weak_pred", 32'(pred_taken_if), 32'd0);
      check("t2_weak_npc", npc, 32'h104);

      // 3: alias on index 0
      ex_update(32'h100, 1, 32'h200); cycle();
      ex_idle(); pc_if = 32'h140; #1;
      check("t3_alias_npc", npc, 32'h144);
      ex_update(32'h140, 1, 32'h300); cycle();
      ex_idle(); #1;
      check("t3_new_npc", npc, 32'h300);
      pc_if = 32'h100; #1;
      check("t3_evicted_npc", npc, 32'h104);

      // 4: redirect overrides stall, stall holds metadata
      pc_if = 32'h140; cycle();
      check("t4_id_loaded", 32'(pred_taken_id), 32'd1);
      stall_if = 1; ex_mispredict = 1; ex_correct_pc = 32'h400; #1;
      check("t4_ce", 32'(pc_ce), 32'd1);
      check("t4_npc", npc, 32'h400);
      cycle();
      check("t4_flush", 32'(pred_taken_id), 32'd0);
      stall_if = 0; ex_idle(); cycle();
      stall_if = 1; #1;
      check("t4_stall_ce", 32'(pc_ce), 32'd0);
      cycle();
      check("t4_hold", pred_target_id, 32'h300);
      stall_if = 0;

      // 5: same-cycle lookup and update; wraparound
      ex_update(32'h140, 0, 32'h0); #1;
      check("t5_old", 32'(pred_taken_if), 32'd1);
      cycle();
      ex_idle(); #1;
      check("t5_new", 32'(pred_taken_if), 32'd0);
      pc_if = 32'hFFFF_FFFC; #1;
      check("t5_wrap", npc, 32'h0);
      cycle();

      // 6: reset beats update and redirect
      pc_if = 32'h140;
      ex_update(32'h140, 1, 32'h500); cycle();
      rst = 1; ex_update(32'h200, 1, 32'h600);
      ex_mispredict = 1; ex_correct_pc = 32'h700;
      cycle();
      rst = 0; ex_idle(); pc_if = 32'h200; #1;
      check("t6_miss", 32'(pred_taken_if), 32'd0);
      check("t6_npc", npc, 32'h204);
      check("t6_id", 32'(pred_taken_id), 32'd0);
      pc_if = 32'h140; #1;
      check("t6_cleared", 32'(pred_taken_if), 32'd0);

      // Random traffic over a small address pool so hits and aliases are frequent
      for (int n = 0; n < 400; n++) begin
         pc_if         = {($urandom_range(0, 1) ? 20'h00001 : 20'h0), 6'(0), 4'($urandom_range(0, 15)), 2'b00};
         pc_if[9:6]    = 4'($urandom_range(0, 3));
         stall_if      = ($urandom_range(0, 3) == 0);
         rst           = ($urandom_range(0, 79) == 0);
         ex_valid      = ($urandom_range(0, 3) != 0);
         ex_is_branch  = ($urandom_range(0, 4) != 0);
         ex_pc         = {20'h0, 2'b00, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
         ex_taken      = $urandom_range(0, 1) == 1;
         ex_target     = $urandom & 32'hFFFF_FFFC;
         ex_mispredict = ($urandom_range(0, 7) == 0);
         ex_correct_pc = $urandom & 32'hFFFF_FFFC;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
